// File: rtl/riscv_pkg.sv
// Purpose: shared RV32 fetch-path widths, constants and the fetch-queue entry type.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
// Contents: XLEN/ILEN, INSTR_NOP, DEFAULT_RESET_PC, fq_entry_t, word_align().
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  // addi x0, x0, 0
  localparam logic [ILEN-1:0] INSTR_NOP = 32'h0000_0013;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // One fetch-queue slot: the instruction and the byte address it came from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fq_entry_t;

  // Force a byte address onto a 4-byte instruction boundary.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Purpose: generic synchronous FIFO with a single-cycle flush, used as the fetch queue.
// Latency: an entry pushed at edge N is visible on rd_dat from cycle N+1 (head read is combinational).
// Backpressure: push is ignored when full unless a pop happens in the same cycle; flush wins over push/pop.
// Ports: clk, rst_n (async active-low); flush; push + wr_dat; pop; rd_dat (head), full, empty, count.
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [W-1:0]           wr_dat,
  input  logic                   pop,
  output logic [W-1:0]           rd_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          wr_en;
  logic          rd_en;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  // A push into a full queue is legal only alongside a pop: the write lands in
  // the slot being vacated, since wr_ptr == rd_ptr when full.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Storage is cleared too so the head reads zero straight out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      // Slot contents are left in place; only the bookkeeping is discarded.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_en && !rd_en) begin
        count <= count + 1'b1;
      end else if (rd_en && !wr_en) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Purpose: instruction-fetch stage; owns the PC, reads the combinational ROM, queues {pc, instr} for decode.
// Latency: an instruction fetched at edge N is offered to decode in cycle N+1; one instruction per cycle sustained.
// Backpressure: id_ready low fills the queue, then the PC holds; a redirect masks id_valid and flushes the queue.
// Ports: clk, rst_n; imem_addr/imem_instr (ROM); fetch_en; redirect_valid/redirect_pc;
//        id_valid/id_ready handshake with id_pc, id_instr, id_pc_plus4 toward decode.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;

  logic [XLEN-1:0] pc_q;
  logic            loaded_q;
  logic            push;
  logic            pop;
  logic            fq_full;
  logic            fq_empty;
  logic [CW-1:0]   fq_count;
  fq_entry_t       wr_entry;
  fq_entry_t       head;

  // The ROM address comes straight from the PC flop so no input reaches it
  // combinationally.
  assign imem_addr = pc_q;

  // A redirect hides the head in the same cycle so decode can never take a
  // wrong-path instruction while execute is steering elsewhere.
  assign id_valid = !fq_empty && !redirect_valid;
  assign pop      = id_valid && id_ready;

  // A full queue still accepts a fetch when the head leaves in the same cycle.
  assign push = fetch_en && !redirect_valid && (!fq_full || pop);

  assign wr_entry = '{pc: pc_q, instr: imem_instr};

  fetch_queue #(
    .DEPTH (FQ_DEPTH),
    .W     ($bits(fq_entry_t))
  ) u_fetch_queue (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (redirect_valid),
    .push   (push),
    .wr_dat (wr_entry),
    .pop    (pop),
    .rd_dat (head),
    .full   (fq_full),
    .empty  (fq_empty),
    .count  (fq_count)
  );

  assign id_pc    = head.pc;
  assign id_instr = head.instr;

  // Before the first fetch the head slot is all zero and pc+4 must read zero
  // as well; afterwards it simply tracks the (possibly stale) head PC.
  assign id_pc_plus4 = loaded_q ? (head.pc + 32'd4) : '0;

  // Program counter: redirect beats everything, otherwise advance on each fetch.
  // Wrap-around from 0xFFFF_FFFC to 0 is the natural 32-bit overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (redirect_valid) begin
      pc_q <= word_align(redirect_pc);
    end else if (push) begin
      pc_q <= pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loaded_q <= 1'b0;
    end else if (push) begin
      loaded_q <= 1'b1;
    end
  end

  // Occupancy bookkeeping inside the queue must stay self-consistent.
  a_count_bounds: assert property (@(posedge clk) disable iff (!rst_n)
    (fq_count <= CW'(FQ_DEPTH)) && ((fq_count == '0) == fq_empty));

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;

  int n_chk  = 0;
  int n_fail = 0;

  // Instruction ROM contents: the four program words, then a fixed scramble.
  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0050_0093;
      32'h4:   return 32'h0030_8113;
      32'h8:   return 32'h0021_01B3;
      32'hC:   return INSTR_NOP;
      default: return {a[31:2] ^ 30'h2AB5_1C3D, 2'b11};
    endcase
  endfunction

  assign imem_instr = rom(imem_addr);

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .FQ_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_instr       (id_instr),
    .id_pc_plus4    (id_pc_plus4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached with %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    #1;
    chk("reset id_valid", 32'(id_valid), 32'h0);
    chk("reset imem_addr", imem_addr, 32'h0);
    chk("reset id_pc", id_pc, 32'h0);
    chk("reset id_instr", id_instr, 32'h0);
    chk("reset id_pc_plus4", id_pc_plus4, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One directed cycle: optional reset first, inputs, expected outputs.
  typedef struct {
    bit          rst;
    bit          fen;
    bit          rdy;
    bit          red;
    logic [31:0] rpc;
    bit          e_vld;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  function automatic vec_t mk(bit rst, bit fen, bit rdy, bit red, logic [31:0] rpc,
                              bit ev, logic [31:0] ea, logic [31:0] ep, logic [31:0] ei);
    vec_t v;
    v.rst = rst; v.fen = fen; v.rdy = rdy; v.red = red; v.rpc = rpc;
    v.e_vld = ev; v.e_addr = ea; v.e_pc = ep; v.e_instr = ei;
    return v;
  endfunction

  vec_t      vecs[$];
  fq_entry_t mq[$];
  logic [31:0] m_pc;

  initial begin
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // Streaming from reset, one per cycle.
    vecs.push_back(mk(1, 1, 1, 0, 32'h0, 0, 32'h0,  32'h0, 32'h0));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0, 1, 32'h4,  32'h0, 32'h0050_0093));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0, 1, 32'h8,  32'h4, 32'h0030_8113));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0, 1, 32'hC,  32'h8, 32'h0021_01B3));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0, 1, 32'h10, 32'hC, 32'h0000_0013));
    // Decode stalled for 6 cycles: queue fills, PC parks at 0x8, head stable.
    vecs.push_back(mk(1, 1, 0, 0, 32'h0, 0, 32'h0,  32'h0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0, 1, 32'h4,  32'h0, 32'h0050_0093));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(0, 1, 0, 0, 32'h0, 1, 32'h8, 32'h0, 32'h0050_0093));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0, 1, 32'h8,  32'h0, 32'h0050_0093));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0, 1, 32'hC,  32'h4, 32'h0030_8113));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0, 1, 32'h10, 32'h8, 32'h0021_01B3));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0, 1, 32'h14, 32'hC, 32'h0000_0013));
    // Full queue {0x4, 0x8}, redirect to 0x20, then misaligned and wrapping redirects.
    vecs.push_back(mk(1, 1, 1, 0, 32'h0,  0, 32'h0,  32'h0, 32'h0));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0,  1, 32'h4,  32'h0, 32'h0050_0093));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,  1, 32'h8,  32'h4, 32'h0030_8113));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,  1, 32'hC,  32'h4, 32'h0030_8113));
    vecs.push_back(mk(0, 1, 1, 1, 32'h20, 0, 32'hC,  32'h0, 32'h0));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0,  0, 32'h20, 32'h0, 32'h0));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0,  1, 32'h24, 32'h20, rom(32'h20)));
    vecs.push_back(mk(0, 1, 1, 1, 32'h23, 0, 32'h28, 32'h0, 32'h0));
    vecs.push_back(mk(0, 1, 1, 1, 32'hFFFF_FFFC, 0, 32'h20, 32'h0, 32'h0));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0,  0, 32'hFFFF_FFFC, 32'h0, 32'h0));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0,  1, 32'h0, 32'hFFFF_FFFC, rom(32'hFFFF_FFFC)));
    // fetch_en low drains two entries, PC holds, then fetch resumes.
    vecs.push_back(mk(1, 1, 0, 0, 32'h0, 0, 32'h0, 32'h0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0, 1, 32'h4, 32'h0, 32'h0050_0093));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0, 1, 32'h8, 32'h0, 32'h0050_0093));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0, 1, 32'h8, 32'h4, 32'h0030_8113));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0, 0, 32'h8, 32'h0, 32'h0));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0, 0, 32'h8, 32'h0, 32'h0));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0, 1, 32'hC, 32'h8, 32'h0021_01B3));

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      @(negedge clk);
      fetch_en       = vecs[i].fen;
      id_ready       = vecs[i].rdy;
      redirect_valid = vecs[i].red;
      redirect_pc    = vecs[i].rpc;
      #1;
      chk($sformatf("vec%0d id_valid", i), 32'(id_valid), 32'(vecs[i].e_vld));
      chk($sformatf("vec%0d imem_addr", i), imem_addr, vecs[i].e_addr);
      if (vecs[i].e_vld) begin
        chk($sformatf("vec%0d id_pc", i), id_pc, vecs[i].e_pc);
        chk($sformatf("vec%0d id_instr", i), id_instr, vecs[i].e_instr);
        chk($sformatf("vec%0d id_pc_plus4", i), id_pc_plus4, vecs[i].e_pc + 32'd4);
      end
    end

    // Asynchronous reset in the middle of a stream.
    do_reset();
    fetch_en = 1'b1;
    id_ready = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("stream id_valid", 32'(id_valid), 32'h1);
    chk("stream imem_addr", imem_addr, 32'h14);
    chk("stream id_pc", id_pc, 32'h10);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async id_valid", 32'(id_valid), 32'h0);
    chk("async imem_addr", imem_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("restart idle addr", imem_addr, 32'h0);
    chk("restart idle valid", 32'(id_valid), 32'h0);
    @(negedge clk);
    #1;
    chk("restart id_valid", 32'(id_valid), 32'h1);
    chk("restart id_pc", id_pc, 32'h0);
    chk("restart id_instr", id_instr, 32'h0050_0093);
    chk("restart imem_addr", imem_addr, 32'h4);

    // Randomised traffic against a queue-based reference model.
    do_reset();
    m_pc = 32'h0;
    mq.delete();
    for (int c = 0; c < 2000; c++) begin
      bit ev;
      bit pop;
      bit push;
      @(negedge clk);
      fetch_en       = ($urandom_range(0, 9) < 8);
      id_ready       = ($urandom_range(0, 9) < 6);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : 32'($urandom);
      #1;
      ev = (mq.size() != 0) && !redirect_valid;
      chk("rnd id_valid", 32'(id_valid), 32'(ev));
      chk("rnd imem_addr", imem_addr, m_pc);
      if (ev) begin
        chk("rnd id_pc", id_pc, mq[0].pc);
        chk("rnd id_instr", id_instr, mq[0].instr);
        chk("rnd id_pc_plus4", id_pc_plus4, mq[0].pc + 32'd4);
      end
      if (redirect_valid) begin
        mq.delete();
        m_pc = redirect_pc & ~32'h3;
      end else begin
        pop  = ev && id_ready;
        push = fetch_en && ((mq.size() < DEPTH) || pop);
        if (pop) void'(mq.pop_front());
        if (push) begin
          mq.push_back('{pc: m_pc, instr: rom(m_pc)});
          m_pc = m_pc + 32'd4;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the combinational instruction ROM and feeds the decode stage.
- Owns the program counter and drives the ROM byte address.
- Captures the returned instruction word, together with its PC, into a small fetch queue.
- Presents the queue head to decode over a valid/ready handshake.
- Handles control-flow redirects from execute by flushing the queue and reloading the PC.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned
FQ_DEPTH, 2, fetch-queue entries; power of two, >= 2

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
imem_addr  output  32  byte address to instruction ROM; always equals PC register
imem_instr  input  32  instruction word returned combinationally for imem_addr
fetch_en  input  1  1 = fetching allowed; 0 = PC holds, no pushes
redirect_valid  input  1  branch/jump taken in execute; single-cycle pulse or level
redirect_pc  input  32  redirect target byte address
id_valid  output  1  queue head valid toward decode
id_ready  input  1  decode accepts head this cycle
id_pc  output  32  PC of head instruction
id_instr  output  32  head instruction word
id_pc_plus4  output  32  id_pc + 4, modulo 2^32

Behaviour:
- Reset (async assert, sync release): PC = RESET_PC; queue count, read and write pointers = 0; id_valid = 0; id_pc, id_instr and id_pc_plus4 read 0.
- imem_addr = PC register. No combinational path from any input to imem_addr.
- push = fetch_en && !redirect_valid && (count < FQ_DEPTH || pop).
  - On push, enqueue {PC, imem_instr} and set PC <= PC + 4.
  - PC wraps: 32'hFFFF_FFFC + 4 = 32'h0.
- pop = id_valid && id_ready. Dequeues the head.
- id_valid = (count != 0) && !redirect_valid. A redirect masks the head combinationally, so decode never accepts a wrong-path instruction in the redirect cycle.
- Redirect cycle:
  - PC <= {redirect_pc[31:2], 2'b00}; bits [1:0] are cleared.
  - count and pointers are cleared and all queued entries are discarded.
  - No push and no pop.
  - Redirect has priority over fetch_en, push and pop.
- Latency: an instruction fetched (pushed) in cycle N is presented at the id_* outputs in cycle N+1 at the earliest. After reset release, the first id_valid = 1 occurs one cycle after the first fetch-enabled clock edge.
- Throughput: one instruction per cycle when id_ready is held at 1.
- Full queue: a push is still allowed if a pop occurs in the same cycle (count unchanged). Otherwise PC holds and imem_addr is stable.
- Empty queue: id_valid = 0. id_pc and id_instr hold the stale head contents; decode must ignore them.
- fetch_en = 0: PC holds, the queue drains normally via pops.
- Stalled head: id_pc, id_instr and id_pc_plus4 are stable while id_valid = 1 and id_ready = 0.
- Reset asserted mid-operation: everything clears immediately without waiting for a clock edge. In-flight entries are lost.
- Count width: clog2(FQ_DEPTH)+1 bits. Pointers are clog2(FQ_DEPTH) bits and wrap naturally.

Decomposition:
- Shared package riscv_pkg:
  - XLEN = 32
  - ILEN = 32
  - INSTR_NOP = 32'h0000_0013
  - default RESET_PC
  - fetch-queue entry struct {pc[31:0], instr[31:0]}
- Sub-module fetch_queue: synchronous FIFO with a flush input.
  - Parameters: depth and entry width.
  - Ports: push/pop/flush, full/empty/count.
  - fetch_unit contains the PC register, next-PC logic and the handshake masking.

Test Plan:
1. Release reset, fetch_en = 1, id_ready = 1 → id_valid rises one cycle after the first edge. Decode sees (pc, instr) = (0x0, 00500093), (0x4, 00308113), (0x8, 002101B3), then (0xC, 00000013) on consecutive cycles.
2. id_ready = 0 for 6 cycles from reset → queue fills with pc 0x0 and 0x4; imem_addr holds at 0x8; head stable at (0x0, 00500093). On release, pc 0x0, 0x4, 0x8 are each delivered exactly once, in order, with no gap.
3. Queue full with pc 0x4 and 0x8; pulse redirect_valid with redirect_pc = 0x20 and id_ready = 1 → id_valid = 0 that cycle with no pop. Next cycle imem_addr = 0x20 and id_valid = 0. The cycle after that, id_pc = 0x20 and id_pc_plus4 = 0x24.
4. Redirect to 0x23 → imem_addr = 0x20. Redirect to 0xFFFF_FFFC followed by one fetch → next imem_addr = 0x0.
5. fetch_en = 0 while queue holds 2 → both entries drain over 2 cycles, then id_valid = 0 and imem_addr is unchanged. Raising fetch_en resumes from the held PC.
6. Assert rst_n = 0 mid-cycle while streaming → id_valid = 0 and imem_addr = RESET_PC before the next clock edge. After release, the stream restarts at pc 0x0.
